ttl_jk_op_sequencer: RTL and testbench
======================================

// Module: ttl_jk_op_sequencer
// PURPOSE
//  Sequences a bank of negative-edge J-K flip-flops with active-low clear, one per block.
//  Accepts one operation at a time over a Start/Ready handshake: HOLD, RESET, SET, TOGGLE or CLEAR, per-block masked.
//  Generates J, K, flip-flop clock and Clear_bar with programmable setup, pulse and recovery timing.
//  Samples Q back after each operation; reports Done and an optional expected-state mismatch.
// PARAMETERS
//  BLOCKS        2  number of flip-flops driven
//  SETUP_CYCLES  1  cycles J/K are stable with JK_Clk high before the falling edge (0 treated as 1)
//  PULSE_CYCLES  1  cycles JK_Clk (or JK_Clear_bar) held low (0 treated as 1)
//  HOLD_CYCLES   1  cycles J/K held after JK_Clk returns high (0 treated as 1)
// PORTS
//  Clk           in   1       system clock, all state on rising edge
//  Reset         in   1       synchronous, active-high
//  Start         in   1       request; accepted when Start && Ready
//  Op            in   3       000 HOLD, 001 RESET, 010 SET, 011 TOGGLE, 100 CLEAR, 101-111 reserved
//  Block_Mask    in   BLOCKS  1 = block participates; ignored for CLEAR
//  Ready         out  1       high only in IDLE
//  Done          out  1       one-cycle pulse at end of operation
//  JK_J          out  BLOCKS  J to flip-flops
//  JK_K          out  BLOCKS  K to flip-flops
//  JK_Clk        out  BLOCKS  flip-flop clocks, idle high
//  JK_Clear_bar  out  BLOCKS  flip-flop clears, idle high
//  JK_Q          in   BLOCKS  flip-flop Q readback
//  Q_Capture     out  BLOCKS  JK_Q sampled in CHECK state
//  Mismatch      out  1       Q_Capture differs from expected on a known bit (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (any state, mid-operation included): next edge -> IDLE. Ready=1, Done=0, JK_J=0, JK_K=0, JK_Clk=all 1.
//    Also JK_Clear_bar=all 1, Q_Capture=0, Mismatch=0, expected model Known=0.
//  - States: IDLE -> SETUP -> PULSE -> RECOVER -> CHECK -> IDLE. One shared down-counter is loaded on each state entry.
//  - IDLE: on Start&&Ready, latch Op and Block_Mask. Start is ignored outside IDLE.
//  - SETUP (SETUP_CYCLES): drive J/K from the latched Op on masked blocks. Unmasked blocks get J=K=0.
//    RESET drives J=0 K=1; SET drives J=1 K=0; TOGGLE drives J=1 K=1; HOLD, CLEAR and reserved drive J=K=0.
//  - PULSE (PULSE_CYCLES): for non-CLEAR ops, JK_Clk=0 on masked blocks; the flip-flop acts on the 1->0 edge.
//    For CLEAR, JK_Clear_bar=0 on all blocks and JK_Clk stays high. HOLD and reserved pulse nothing.
//  - RECOVER (HOLD_CYCLES): JK_Clk and JK_Clear_bar return high; J/K are unchanged.
//  - CHECK (1 cycle): Q_Capture<=JK_Q, Mismatch updated, Done=1, J/K return to 0; next state IDLE.
//  - Ready is first high the cycle after Done, so back-to-back ops have 1 idle cycle minimum.
//  - Latency from Start accepted to Done = SETUP_CYCLES+PULSE_CYCLES+HOLD_CYCLES+1 cycles.
//  - Reserved Op: executes as HOLD and still completes with Done.
// CONFIGURATION
//  Macro TTL_JK_SEQ_CHECK_EN.
//  - Defined: an expected model is kept as Expected[BLOCKS] plus Known[BLOCKS], updated in CHECK.
//    CLEAR sets Expected=0 and Known=all.
//    SET and RESET on masked bits set Known=1 and Expected=1 or 0 respectively.
//    TOGGLE inverts Expected on masked bits; Known is unchanged.
//    Mismatch <= |((JK_Q ^ Expected_next) & Known_next), where Expected_next and Known_next include this op's update.
//    Mismatch holds until the next CHECK or Reset.
//  - Undefined: no model logic; Mismatch tied 0.
// TESTING
//  - Reset then idle: Ready=1, JK_Clk=11, JK_Clear_bar=11, J=K=00. Reset asserted in PULSE returns JK_Clk=11 next edge.
//  - Defaults, Op=100: JK_Clear_bar=00 exactly 1 cycle; Done 4 cycles after accept; Q_Capture=00, Mismatch=0.
//  - SET mask=01, then TOGGLE mask=11 with flip-flop models attached:
//    Q_Capture=01 then 10; block1 unknown before TOGGLE so Mismatch=0.
//  - SETUP=3, PULSE=2, HOLD=2, Op=001: J=0 K=1 for 7 cycles; JK_Clk low 2 cycles; Done at cycle 8 after accept.
//  - Start held high continuously: ops accepted every 5 cycles (defaults); no Start taken while busy.
//  - CHECK_EN: force JK_Q=00 after SET mask=11 -> Mismatch=1. Macro undefined -> Mismatch=0.

Source files
------------

// File: rtl/ttl_jk_op_sequencer_if.sv
// Request/status bundle between an op issuer and the J-K flip-flop sequencer.
// The master side also returns the flip-flop Q readback.
interface ttl_jk_op_sequencer_if #(
   parameter int BLOCKS = 2
);
   logic              Start;
   logic [2:0]        Op;
   logic [BLOCKS-1:0] Block_Mask;
   logic              Ready;
   logic              Done;
   logic [BLOCKS-1:0] JK_J;
   logic [BLOCKS-1:0] JK_K;
   logic [BLOCKS-1:0] JK_Clk;
   logic [BLOCKS-1:0] JK_Clear_bar;
   logic [BLOCKS-1:0] JK_Q;
   logic [BLOCKS-1:0] Q_Capture;
   logic              Mismatch;

   modport master (
      output Start, Op, Block_Mask, JK_Q,
      input  Ready, Done, JK_J, JK_K, JK_Clk, JK_Clear_bar, Q_Capture, Mismatch
   );

   modport slave (
      input  Start, Op, Block_Mask, JK_Q,
      output Ready, Done, JK_J, JK_K, JK_Clk, JK_Clear_bar, Q_Capture, Mismatch
   );
endinterface

// File: rtl/ttl_jk_op_sequencer.sv
// Drives a bank of negative-edge J-K flip-flops through setup/pulse/recover/check; one op in flight.
// Done comes SETUP+PULSE+HOLD+1 cycles after accept; Start is only taken in IDLE. TTL_JK_SEQ_CHECK_EN adds the expected-state model.
module ttl_jk_op_sequencer #(
   parameter int BLOCKS       = 2,
   parameter int SETUP_CYCLES = 1,
   parameter int PULSE_CYCLES = 1,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   ttl_jk_op_sequencer_if.slave   bus
);
   localparam int S_EFF   = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
   localparam int P_EFF   = (PULSE_CYCLES < 1) ? 1 : PULSE_CYCLES;
   localparam int H_EFF   = (HOLD_CYCLES  < 1) ? 1 : HOLD_CYCLES;
   localparam int MAX_SP  = (S_EFF > P_EFF) ? S_EFF : P_EFF;
   localparam int MAX_EFF = (MAX_SP > H_EFF) ? MAX_SP : H_EFF;
   localparam int CNT_W   = (MAX_EFF > 1) ? $clog2(MAX_EFF) : 1;

   localparam logic [2:0] OP_RESET  = 3'b001;
   localparam logic [2:0] OP_SET    = 3'b010;
   localparam logic [2:0] OP_TOGGLE = 3'b011;
   localparam logic [2:0] OP_CLEAR  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_RECOVER,
      ST_CHECK
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q;
   logic [BLOCKS-1:0] mask_q;
   logic [BLOCKS-1:0] q_capture_q;
   logic              accept;
   logic [BLOCKS-1:0] j_pat, k_pat;
   logic              pulse_clk, pulse_clr;
   logic              drive_jk;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         mask_q      <= '0;
         q_capture_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            op_q   <= bus.Op;
            mask_q <= bus.Block_Mask;
         end
         if (state_q == ST_CHECK) q_capture_q <= bus.JK_Q;
      end
   end

   // The shared counter is loaded with (cycles-1) on entry and the state exits when it reaches zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.Start) begin
               accept  = 1'b1;
               state_d = ST_SETUP;
               cnt_d   = CNT_W'(S_EFF - 1);
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE;
               cnt_d   = CNT_W'(P_EFF - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_RECOVER;
               cnt_d   = CNT_W'(H_EFF - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) state_d = ST_CHECK;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_CHECK: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // HOLD and reserved codes fall through to no J/K and no pulse.
   always_comb begin
      j_pat     = '0;
      k_pat     = '0;
      pulse_clk = 1'b0;
      pulse_clr = 1'b0;
      case (op_q)
         OP_RESET: begin
            k_pat     = mask_q;
            pulse_clk = 1'b1;
         end
         OP_SET: begin
            j_pat     = mask_q;
            pulse_clk = 1'b1;
         end
         OP_TOGGLE: begin
            j_pat     = mask_q;
            k_pat     = mask_q;
            pulse_clk = 1'b1;
         end
         OP_CLEAR: pulse_clr = 1'b1;
         default: ;
      endcase
   end

   assign drive_jk         = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_RECOVER);
   assign bus.Ready        = (state_q == ST_IDLE);
   assign bus.Done         = (state_q == ST_CHECK);
   assign bus.JK_J         = drive_jk ? j_pat : '0;
   assign bus.JK_K         = drive_jk ? k_pat : '0;
   assign bus.JK_Clk       = ((state_q == ST_PULSE) && pulse_clk) ? ~mask_q : '1;
   assign bus.JK_Clear_bar = ((state_q == ST_PULSE) && pulse_clr) ? '0 : '1;
   assign bus.Q_Capture    = q_capture_q;

`ifdef TTL_JK_SEQ_CHECK_EN
   logic [BLOCKS-1:0] expected_q, known_q;
   logic [BLOCKS-1:0] expected_nx, known_nx;
   logic              mismatch_q;

   always_comb begin
      expected_nx = expected_q;
      known_nx    = known_q;
      case (op_q)
         OP_CLEAR: begin
            expected_nx = '0;
            known_nx    = '1;
         end
         OP_SET: begin
            expected_nx = expected_q | mask_q;
            known_nx    = known_q | mask_q;
         end
         OP_RESET: begin
            expected_nx = expected_q & ~mask_q;
            known_nx    = known_q | mask_q;
         end
         OP_TOGGLE: expected_nx = expected_q ^ mask_q;
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         expected_q <= '0;
         known_q    <= '0;
         mismatch_q <= 1'b0;
      end else if (state_q == ST_CHECK) begin
         expected_q <= expected_nx;
         known_q    <= known_nx;
         mismatch_q <= |((bus.JK_Q ^ expected_nx) & known_nx);
      end
   end

   assign bus.Mismatch = mismatch_q;
`else
   assign bus.Mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_ttl_jk_op_sequencer.sv
// Bench for ttl_jk_op_sequencer: default-timing and 3/2/2-timing instances, each with a J-K flip-flop bank model.
// Directed ops, held Start, reset mid-pulse, then random ops against a reference model.
module tb_ttl_jk_op_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst        [2];
   logic       start      [2];
   logic [2:0] op         [2];
   logic [1:0] mask       [2];
   logic       force_zero [2];

   logic       ready [2];
   logic       done  [2];
   logic       mis   [2];
   logic [1:0] jj    [2];
   logic [1:0] kk    [2];
   logic [1:0] jclk  [2];
   logic [1:0] clrb  [2];
   logic [1:0] qcap  [2];

   logic [1:0] ffq_a  = 2'b00;
   logic [1:0] ffq_b  = 2'b00;
   logic [1:0] pclk_a = 2'b11;
   logic [1:0] pclk_b = 2'b11;

   logic [1:0] m_q     [2];
   logic [1:0] m_exp   [2];
   logic [1:0] m_known [2];

   int n_pass  = 0;
   int n_total = 0;

   ttl_jk_op_sequencer_if #(.BLOCKS(2)) bus_a ();
   ttl_jk_op_sequencer_if #(.BLOCKS(2)) bus_b ();

   ttl_jk_op_sequencer #(
      .BLOCKS(2), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1)
   ) dut_a (
      .Clk   (clk),
      .Reset (rst[0]),
      .bus   (bus_a.slave)
   );

   ttl_jk_op_sequencer #(
      .BLOCKS(2), .SETUP_CYCLES(3), .PULSE_CYCLES(2), .HOLD_CYCLES(2)
   ) dut_b (
      .Clk   (clk),
      .Reset (rst[1]),
      .bus   (bus_b.slave)
   );

   assign bus_a.Start      = start[0];
   assign bus_a.Op         = op[0];
   assign bus_a.Block_Mask = mask[0];
   assign bus_a.JK_Q       = force_zero[0] ? 2'b00 : ffq_a;
   assign bus_b.Start      = start[1];
   assign bus_b.Op         = op[1];
   assign bus_b.Block_Mask = mask[1];
   assign bus_b.JK_Q       = force_zero[1] ? 2'b00 : ffq_b;

   assign ready[0] = bus_a.Ready;        assign ready[1] = bus_b.Ready;
   assign done[0]  = bus_a.Done;         assign done[1]  = bus_b.Done;
   assign mis[0]   = bus_a.Mismatch;     assign mis[1]   = bus_b.Mismatch;
   assign jj[0]    = bus_a.JK_J;         assign jj[1]    = bus_b.JK_J;
   assign kk[0]    = bus_a.JK_K;         assign kk[1]    = bus_b.JK_K;
   assign jclk[0]  = bus_a.JK_Clk;       assign jclk[1]  = bus_b.JK_Clk;
   assign clrb[0]  = bus_a.JK_Clear_bar; assign clrb[1]  = bus_b.JK_Clear_bar;
   assign qcap[0]  = bus_a.Q_Capture;    assign qcap[1]  = bus_b.Q_Capture;

   // Negative-edge J-K flip-flop with asynchronous active-low clear.
   function automatic logic [1:0] ff_next(input logic [1:0] q, input logic [1:0] pc,
                                          input logic [1:0] cc, input logic [1:0] cl,
                                          input logic [1:0] j, input logic [1:0] k);
      logic [1:0] r;
      r = q;
      for (int i = 0; i < 2; i++) begin
         if (cl[i] === 1'b0) r[i] = 1'b0;
         else if (pc[i] === 1'b1 && cc[i] === 1'b0) begin
            if (j[i] === 1'b1 && k[i] === 1'b1)      r[i] = ~q[i];
            else if (j[i] === 1'b1)                  r[i] = 1'b1;
            else if (k[i] === 1'b1)                  r[i] = 1'b0;
         end
      end
      return r;
   endfunction

   always @(jclk[0] or clrb[0]) begin
      ffq_a  = ff_next(ffq_a, pclk_a, jclk[0], clrb[0], jj[0], kk[0]);
      pclk_a = jclk[0];
   end

   always @(jclk[1] or clrb[1]) begin
      ffq_b  = ff_next(ffq_b, pclk_b, jclk[1], clrb[1], jj[1], kk[1]);
      pclk_b = jclk[1];
   end

   function automatic int s_of(input int d); return (d == 0) ? 1 : 3; endfunction
   function automatic int p_of(input int d); return (d == 0) ? 1 : 2; endfunction
   function automatic int h_of(input int d); return (d == 0) ? 1 : 2; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference behaviour of one op on the flip-flop bank and on the expected-state model.
   task automatic model_apply(input int d, input logic [2:0] o, input logic [1:0] m);
      case (o)
         3'd1: begin m_q[d] &= ~m; m_exp[d] &= ~m; m_known[d] |= m; end
         3'd2: begin m_q[d] |= m;  m_exp[d] |= m;  m_known[d] |= m; end
         3'd3: begin m_q[d] ^= m;  m_exp[d] ^= m; end
         3'd4: begin m_q[d] = 2'b00; m_exp[d] = 2'b00; m_known[d] = 2'b11; end
         default: ;
      endcase
   endtask

   function automatic logic exp_mismatch(input int d, input logic [1:0] obs);
`ifdef TTL_JK_SEQ_CHECK_EN
      return |((obs ^ m_exp[d]) & m_known[d]);
`else
      return 1'b0;
`endif
   endfunction

   task automatic wait_ready(input int d);
      int n;
      n = 0;
      while (ready[d] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_op", 32'(ready[d]), 32'd1);
   endtask

   task automatic do_op(input int d, input logic [2:0] o, input logic [1:0] m);
      int lat, nz, jk_bad, clk_low, clk_bad, clr_low, clr_bad, rdy_busy, pulse_exp;
      logic [1:0] ej, ek, obs;
      lat = 0; nz = 0; jk_bad = 0; clk_low = 0; clk_bad = 0;
      clr_low = 0; clr_bad = 0; rdy_busy = 0;
      ej = (o == 3'd2 || o == 3'd3) ? m : 2'b00;
      ek = (o == 3'd1 || o == 3'd3) ? m : 2'b00;
      wait_ready(d);
      start[d] = 1'b1; op[d] = o; mask[d] = m;
      @(posedge clk);
      #1 start[d] = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (jj[d] !== 2'b00 || kk[d] !== 2'b00) begin
            nz++;
            if (jj[d] !== ej || kk[d] !== ek) jk_bad++;
         end
         if (jclk[d] !== 2'b11) begin
            clk_low++;
            if (jclk[d] !== ~m) clk_bad++;
         end
         if (clrb[d] !== 2'b11) begin
            clr_low++;
            if (clrb[d] !== 2'b00) clr_bad++;
         end
         if (done[d] === 1'b1) begin
            lat = k;
            break;
         end
         if (ready[d] === 1'b1) rdy_busy++;
      end
      pulse_exp = ((o == 3'd1 || o == 3'd2 || o == 3'd3) && m != 2'b00) ? p_of(d) : 0;
      chk("latency",        32'(lat),      32'(s_of(d) + p_of(d) + h_of(d) + 1));
      chk("jk_drive_cycles", 32'(nz),      32'(((ej | ek) != 2'b00) ? s_of(d) + p_of(d) + h_of(d) : 0));
      chk("jk_value",       32'(jk_bad),   32'd0);
      chk("clk_low_cycles", 32'(clk_low),  32'(pulse_exp));
      chk("clk_low_value",  32'(clk_bad),  32'd0);
      chk("clear_cycles",   32'(clr_low),  32'((o == 3'd4) ? p_of(d) : 0));
      chk("clear_value",    32'(clr_bad),  32'd0);
      chk("ready_busy",     32'(rdy_busy), 32'd0);
      model_apply(d, o, m);
      obs = force_zero[d] ? 2'b00 : m_q[d];
      @(negedge clk);
      chk("ready_after",  32'(ready[d]), 32'd1);
      chk("done_pulse",   32'(done[d]),  32'd0);
      chk("q_capture",    32'(qcap[d]),  32'(obs));
      chk("mismatch",     32'(mis[d]),   32'(exp_mismatch(d, obs)));
   endtask

   task automatic idle_checks(input int d);
      chk("idle_ready",   32'(ready[d]), 32'd1);
      chk("idle_done",    32'(done[d]),  32'd0);
      chk("idle_jk_clk",  32'(jclk[d]),  32'd3);
      chk("idle_clear",   32'(clrb[d]),  32'd3);
      chk("idle_j",       32'(jj[d]),    32'd0);
      chk("idle_k",       32'(kk[d]),    32'd0);
      chk("idle_qcap",    32'(qcap[d]),  32'd0);
      chk("idle_mismatch", 32'(mis[d]),  32'd0);
   endtask

   initial begin
      int dcnt, first, last, rcnt, n;
      logic [1:0] m;
      logic [1:0] obs;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; op[d] = 3'd0; mask[d] = 2'b00; force_zero[d] = 1'b0;
         m_q[d] = 2'b00; m_exp[d] = 2'b00; m_known[d] = 2'b00;
      end
      repeat (3) @(posedge clk);
      #1 rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      idle_checks(0);
      idle_checks(1);

      // Default timing: CLEAR, then SET/TOGGLE walk, forced readback, reserved op.
      do_op(0, 3'd4, 2'($urandom_range(0, 3)));
      do_op(0, 3'd2, 2'b01);
      do_op(0, 3'd3, 2'b11);
      force_zero[0] = 1'b1;
      do_op(0, 3'd2, 2'b11);
      force_zero[0] = 1'b0;
      do_op(0, 3'd6, 2'b11);

      // Stretched timing on the second instance.
      do_op(1, 3'd4, 2'b00);
      do_op(1, 3'd1, 2'b11);
      do_op(1, 3'd2, 2'b10);

      // Start held high: one accept every five cycles.
      wait_ready(0);
      m = 2'($urandom_range(1, 3));
      start[0] = 1'b1; op[0] = 3'd3; mask[0] = m;
      dcnt = 0; first = 0; last = 0; rcnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (done[0] === 1'b1) begin
            dcnt++;
            if (first == 0) first = k;
            last = k;
         end
         if (ready[0] === 1'b1) rcnt++;
         if (k == 20) start[0] = 1'b0;
      end
      for (int i = 0; i < 4; i++) model_apply(0, 3'd3, m);
      chk("held_done_count", 32'(dcnt),  32'd4);
      chk("held_first_done", 32'(first), 32'd4);
      chk("held_last_done",  32'(last),  32'd19);
      chk("held_ready_cyc",  32'(rcnt),  32'd4);
      chk("held_qcap",       32'(qcap[0]), 32'(m_q[0]));

      // Reset during the clock pulse.
      wait_ready(1);
      start[1] = 1'b1; op[1] = 3'd2; mask[1] = 2'b11;
      @(posedge clk);
      #1 start[1] = 1'b0;
      n = 0;
      while (jclk[1] === 2'b11 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("pulse_seen", 32'(jclk[1]), 32'd0);
      rst[1] = 1'b1;
      @(posedge clk);
      #1;
      idle_checks(1);
      rst[1] = 1'b0;
      m_q[1] |= 2'b11; m_exp[1] = 2'b00; m_known[1] = 2'b00;
      @(negedge clk);

      // Random ops on both instances.
      for (int it = 0; it < 16; it++) begin
         for (int d = 0; d < 2; d++) begin
            force_zero[d] = ($urandom_range(0, 7) == 0);
            do_op(d, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            force_zero[d] = 1'b0;
         end
      end

      // A forced-low readback after SET on every bit.
      force_zero[1] = 1'b1;
      do_op(1, 3'd2, 2'b11);
      force_zero[1] = 1'b0;
      obs = m_q[1];
      chk("model_q_after_set", 32'(obs), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
